// File: rtl/rf_mp_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// the address-width helper and the architectural register address type.
package rf_mp_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    // Address width needed to index a register file of nregs entries.
    function automatic int unsigned aw_of(input int unsigned nregs);
        return $clog2(nregs);
    endfunction

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/rf_mp_scoreboard.sv
// Busy-bit scoreboard for rf_mp: one bit per register, set on issue,
// cleared on writeback, wiped on flush. Issue wins over a same-cycle write
// to the same register because the issuing instruction is the younger producer.
module rf_mp_scoreboard
    import rf_mp_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2,
    parameter int unsigned AW    = aw_of(NREGS_DEF)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NRD*AW-1:0] i_raddr,
    input  logic [NRD-1:0]    i_byp_hit,
    input  logic [NWR-1:0]    i_wen,
    input  logic [NWR*AW-1:0] i_waddr,
    input  logic              i_issue,
    input  logic [AW-1:0]     i_issue_rd,
    input  logic              i_flush,
    output logic [NRD-1:0]    o_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW-1:0]    ra;

    // Next-state busy: clear on write, then set on issue, flush overrides both.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (i_wen[j] && i_waddr[j*AW +: AW] != '0) begin
                busy_d[i_waddr[j*AW +: AW]] = 1'b0;
            end
        end
        if (i_issue && i_issue_rd != '0) begin
            busy_d[i_issue_rd] = 1'b1;
        end
        if (i_flush) begin
            busy_d = '0;
        end
    end

    // Busy-bit register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Per-port lookup; x0 never busy, a bypassed operand is already available.
    always_comb begin
        o_busy = '0;
        ra     = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            ra        = i_raddr[k*AW +: AW];
            o_busy[k] = busy_q[ra] && (ra != '0) && !i_byp_hit[k];
        end
    end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file: NRD combinational read ports, NWR synchronous
// write ports (highest port wins on conflict), optional write-to-read bypass.
// Define RF_MP_SCOREBOARD_EN to build the busy scoreboard; otherwise o_busy is
// tied low and the issue/flush inputs are ignored.
module rf_mp
    import rf_mp_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned NREGS     = NREGS_DEF,
    parameter int unsigned NRD       = 2,
    parameter int unsigned NWR       = 2,
    parameter bit          BYPASS_EN = 1'b0,
    localparam int unsigned AW       = aw_of(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NRD*AW-1:0]   i_raddr,
    output logic [NRD*XLEN-1:0] o_rdata,
    output logic [NRD-1:0]      o_busy,
    input  logic [NWR-1:0]      i_wen,
    input  logic [NWR*AW-1:0]   i_waddr,
    input  logic [NWR*XLEN-1:0] i_wdata,
    input  logic                i_issue,
    input  logic [AW-1:0]       i_issue_rd,
    input  logic                i_flush
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [NRD-1:0]  byp_hit;
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    // Storage: later write ports override earlier ones; x0 is never written.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (i_wen[j] && i_waddr[j*AW +: AW] != '0) begin
                    regs_q[i_waddr[j*AW +: AW]] <= i_wdata[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Read muxes with optional bypass (highest matching write port wins).
    always_comb begin
        o_rdata = '0;
        byp_hit = '0;
        ra      = '0;
        rd      = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            ra = i_raddr[k*AW +: AW];
            rd = regs_q[ra];
            if (BYPASS_EN) begin
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (i_wen[j] && i_waddr[j*AW +: AW] == ra) begin
                        rd         = i_wdata[j*XLEN +: XLEN];
                        byp_hit[k] = 1'b1;
                    end
                end
            end
            if (ra == '0) begin
                rd = '0;
            end
            o_rdata[k*XLEN +: XLEN] = rd;
        end
    end

`ifdef RF_MP_SCOREBOARD_EN
    rf_mp_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_raddr    (i_raddr),
        .i_byp_hit  (byp_hit),
        .i_wen      (i_wen),
        .i_waddr    (i_waddr),
        .i_issue    (i_issue),
        .i_issue_rd (i_issue_rd),
        .i_flush    (i_flush),
        .o_busy     (o_busy)
    );
`else
    logic unused_sb;
    assign unused_sb = ^{i_issue, i_issue_rd, i_flush, byp_hit};
    assign o_busy    = '0;
`endif

endmodule

// File: tb/tb_rf_mp.sv
// Self-checking bench for rf_mp: two instances (bypass off / on) share one
// stimulus stream and are checked every cycle against a behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_rf_mp;
    import rf_mp_pkg::*;

`ifdef RF_MP_SCOREBOARD_EN
    localparam bit SbEn = 1'b1;
`else
    localparam bit SbEn = 1'b0;
`endif

    localparam int unsigned AW = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  raddr;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        issue;
    logic [4:0]  issue_rd;
    logic        flush;

    logic [63:0] rdata_n, rdata_b;
    logic [1:0]  busy_n, busy_b;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Behavioural model state.
    logic [31:0] mem_m [32];
    logic [31:0] busy_m;
    bit          model_valid = 1'b0;

    always #5 clk = ~clk;

    rf_mp #(.BYPASS_EN(1'b0)) u_nobyp (
        .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rdata_n), .o_busy(busy_n),
        .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_issue(issue),
        .i_issue_rd(issue_rd), .i_flush(flush)
    );

    rf_mp #(.BYPASS_EN(1'b1)) u_byp (
        .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rdata_b), .o_busy(busy_b),
        .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_issue(issue),
        .i_issue_rd(issue_rd), .i_flush(flush)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] exp_rd(input int k, input bit byp);
        reg_addr_t   a;
        logic [31:0] r;
        a = raddr[k*AW +: AW];
        r = mem_m[a];
        if (byp) begin
            for (int j = 0; j < 2; j++) begin
                if (wen[j] && waddr[j*AW +: AW] == a) r = wdata[j*32 +: 32];
            end
        end
        if (a == 0) r = 32'h0;
        return r;
    endfunction

    function automatic logic exp_busy(input int k, input bit byp);
        reg_addr_t a;
        a = raddr[k*AW +: AW];
        if (!SbEn || a == 0) return 1'b0;
        if (byp) begin
            for (int j = 0; j < 2; j++) begin
                if (wen[j] && waddr[j*AW +: AW] == a) return 1'b0;
            end
        end
        return busy_m[a];
    endfunction

    // Model update at the active edge from the rules of the register file.
    always @(posedge clk) begin
        logic [31:0] m [32];
        logic [31:0] b;
        reg_addr_t   wa;
        if (rst) begin
            for (int i = 0; i < 32; i++) mem_m[i] <= 32'h0;
            busy_m      <= 32'h0;
            model_valid <= 1'b1;
        end else begin
            m = mem_m;
            b = busy_m;
            for (int j = 0; j < 2; j++) begin
                wa = waddr[j*AW +: AW];
                if (wen[j] && wa != 0) begin
                    m[wa] = wdata[j*32 +: 32];
                    b[wa] = 1'b0;
                end
            end
            if (issue && issue_rd != 0) b[issue_rd] = 1'b1;
            if (flush || !SbEn) b = 32'h0;
            mem_m  <= m;
            busy_m <= b;
        end
    end

    // Every-cycle comparison of both instances, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rdata%0d_nobyp", k), rdata_n[k*32 +: 32], exp_rd(k, 1'b0));
                chk($sformatf("busy%0d_nobyp", k), {31'h0, busy_n[k]}, {31'h0, exp_busy(k, 1'b0)});
                chk($sformatf("rdata%0d_byp", k), rdata_b[k*32 +: 32], exp_rd(k, 1'b1));
                chk($sformatf("busy%0d_byp", k), {31'h0, busy_b[k]}, {31'h0, exp_busy(k, 1'b1)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; raddr = '0; wen = '0; waddr = '0; wdata = '0;
        issue = 1'b0; issue_rd = '0; flush = 1'b0;
    endtask

    task automatic rd(input int k, input logic [4:0] a);
        raddr[k*AW +: AW] = a;
    endtask

    task automatic wr(input int j, input logic [4:0] a, input logic [31:0] d);
        wen[j] = 1'b1;
        waddr[j*AW +: AW] = a;
        wdata[j*32 +: 32] = d;
    endtask

    task automatic iss(input logic [4:0] a);
        issue = 1'b1;
        issue_rd = a;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(1) == 0) return 5'($urandom_range(7));
        return 5'($urandom_range(31));
    endfunction

    initial begin
        idle(); rst = 1'b1;
        tick();

        // Reset clears a previously written register.
        idle(); wr(0, 5'd5, 32'hDEADBEEF); iss(5'd5);
        tick();
        idle(); rd(0, 5'd5); #1;
        chk("x5_written", rdata_n[31:0], 32'hDEADBEEF);
        chk("x5_busy_pre_rst", {31'h0, busy_n[0]}, {31'h0, SbEn});
        rst = 1'b1;
        tick();
        idle(); rd(0, 5'd5); rd(1, 5'd5); #1;
        chk("rst_rd0", rdata_n[31:0], 32'h0);
        chk("rst_rd1_byp", rdata_b[63:32], 32'h0);
        chk("rst_busy_nobyp", {30'h0, busy_n}, 32'h0);
        chk("rst_busy_byp", {30'h0, busy_b}, 32'h0);

        // Dual-write conflict: port 1 wins.
        idle(); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22);
        tick();
        idle(); rd(0, 5'd7); #1;
        chk("dual_wr_nobyp", rdata_n[31:0], 32'h22);
        chk("dual_wr_byp", rdata_b[31:0], 32'h22);

        // x0 is hardwired zero and never busy.
        idle(); wr(0, 5'd0, 32'hFFFF); iss(5'd0); rd(0, 5'd0); #1;
        chk("x0_same_cycle_byp", rdata_b[31:0], 32'h0);
        tick();
        idle(); rd(0, 5'd0); #1;
        chk("x0_rd", rdata_n[31:0], 32'h0);
        chk("x0_busy", {31'h0, busy_n[0]}, 32'h0);

        // Bypass: x3 made busy with an old value, then rewritten while port 1 reads.
        idle(); wr(0, 5'd3, 32'h1234); iss(5'd3);
        tick();
        idle(); wr(0, 5'd3, 32'hA5A5A5A5); rd(1, 5'd3); #1;
        chk("bypass_rd", rdata_b[63:32], 32'hA5A5A5A5);
        chk("bypass_busy", {31'h0, busy_b[1]}, 32'h0);
        chk("nobypass_old", rdata_n[63:32], 32'h1234);
        chk("nobypass_busy", {31'h0, busy_n[1]}, {31'h0, SbEn});
        tick();
        idle(); rd(1, 5'd3); #1;
        chk("x3_after_wr", rdata_n[63:32], 32'hA5A5A5A5);
        chk("x3_cleared", {31'h0, busy_n[1]}, 32'h0);

        // Scoreboard sequence on x9, including set-beats-clear.
        idle(); iss(5'd9);
        tick();
        idle(); rd(0, 5'd9); iss(5'd9); wr(1, 5'd9, 32'h99); #1;
        chk("x9_busy", {31'h0, busy_n[0]}, {31'h0, SbEn});
        tick();
        idle(); rd(0, 5'd9); wr(0, 5'd9, 32'h9A); #1;
        chk("x9_set_beats_clear", {31'h0, busy_n[0]}, {31'h0, SbEn});
        chk("x9_byp_not_busy", {31'h0, busy_b[0]}, 32'h0);
        tick();
        idle(); rd(0, 5'd9); #1;
        chk("x9_cleared", {31'h0, busy_n[0]}, 32'h0);
        chk("x9_data", rdata_n[31:0], 32'h9A);

        // Flush drops same-cycle issue but keeps same-cycle write.
        idle(); iss(5'd4);
        tick();
        idle(); rd(0, 5'd4); rd(1, 5'd6); flush = 1'b1; iss(5'd6); wr(0, 5'd4, 32'h4444); #1;
        chk("x4_busy_pre_flush", {31'h0, busy_n[0]}, {31'h0, SbEn});
        tick();
        idle(); rd(0, 5'd4); rd(1, 5'd6); #1;
        chk("flush_busy", {30'h0, busy_n}, 32'h0);
        chk("flush_wr_commit", rdata_n[31:0], 32'h4444);

        // Randomized traffic checked by the every-cycle compare.
        for (int c = 0; c < 2000; c++) begin
            tick();
            rst      = ($urandom_range(63) == 0);
            wen      = 2'($urandom);
            waddr    = {rnd_addr(), rnd_addr()};
            wdata    = {$urandom, $urandom};
            raddr    = {rnd_addr(), rnd_addr()};
            issue    = 1'($urandom);
            issue_rd = rnd_addr();
            flush    = ($urandom_range(15) == 0);
        end
        tick();
        idle();
        tick();
        #5;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
